ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB slave (responder) fronting the single-port frame-buffer SRAM read and written by the DMA master.
//  Decodes address/data phases, inserts wait states, generates byte lanes, flags illegal transfers with ERROR.
//  Sits between the system AHB (HSEL from external decoder) and the SRAM macro (1-cycle read latency).
// PARAMETERS
//  ADDR_W       10  SRAM word-address width; the slave uses HADDR[ADDR_W+1:2] as the word address.
//  WAIT_STATES  0   extra HREADYOUT-low cycles inserted at the start of every data phase (0..15).
// PORTS
//  I_HCLK        in   1   AHB clock; every register is clocked on its rising edge.
//  I_HRESET_N    in   1   asynchronous active-low reset.
//  I_HSEL        in   1   slave select for the current address phase.
//  I_HADDR       in   32  byte address.
//  I_HTRANS      in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11.
//  I_HWRITE      in   1   1 = write.
//  I_HSIZE       in   3   000 byte, 001 halfword, 010 word; any other value is illegal.
//  I_HBURST      in   3   accepted and ignored (the master supplies every beat address).
//  I_HWDATA      in   32  write data (data phase).
//  I_HREADY      in   1   global HREADY; address phase accepted only when it is high.
//  O_HREADYOUT   out  1   slave ready; reset 1.
//  O_HRESP       out  2   OKAY=00, ERROR=01; reset 00.
//  O_HRDATA      out  32  read data; reset 0.
//  O_MEM_CE      out  1   SRAM chip enable; reset 0.
//  O_MEM_WE      out  1   SRAM write enable; reset 0.
//  O_MEM_ADDR    out  ADDR_W  SRAM word address; reset 0.
//  O_MEM_BE      out  4   byte enables, bit n = HWDATA[8n+7:8n]; reset 0.
//  O_MEM_WDATA   out  32  = I_HWDATA (pass-through).
//  I_MEM_RDATA   in   32  SRAM data; valid the cycle after CE & !WE.
// BEHAVIOUR
//  - Accept condition = I_HSEL & I_HREADY & I_HTRANS[1]. On accept, register addr, write, size; BE computed from addr/size.
//  - IDLE or BUSY with HSEL: no accept; zero-wait OKAY.
//  - Illegal transfer: HSIZE>010, halfword with addr[0]=1, or word with addr[1:0]!=0.
//  - Byte lanes (little-endian): byte -> 1<<addr[1:0]; halfword -> addr[1]?1100:0011; word -> 1111.
//  - Data-phase FSM states and outputs:
//    DP_IDLE   : HREADYOUT=1, OKAY.
//    DP_WAIT   : HREADYOUT=0; counter loaded with WAIT_STATES-1 and decremented; at 0 -> DP_WR or DP_RD_REQ.
//    DP_RD_REQ : CE=1, WE=0, ADDR=reg addr; HREADYOUT=0; next state DP_RD_RSP.
//    DP_RD_RSP : HRDATA=I_MEM_RDATA (full word, any size), HREADYOUT=1.
//    DP_WR     : CE=1, WE=1, BE=reg BE, WDATA=I_HWDATA; HREADYOUT=1.
//    DP_ERR1   : HRESP=ERROR, HREADYOUT=0, no SRAM access; next state DP_ERR2.
//    DP_ERR2   : HRESP=ERROR, HREADYOUT=1.
//  - In every HREADYOUT=1 state (IDLE, RD_RSP, WR, ERR2), on accept: illegal -> ERR1; else if WAIT_STATES>0 -> WAIT;
//    else write -> WR, read -> RD_REQ. With no accept -> IDLE. Address pipelining is therefore back-to-back.
//  - Latency with WAIT_STATES=0: write takes 1 data-phase cycle (0 wait); read takes 2 cycles (1 wait).
//  - O_HRDATA = 0 outside DP_RD_RSP. CE/WE/BE = 0 outside RD_REQ/WR.
//  - SRAM is touched only in the data phase, so a read following a write to the same address returns new data.
//  - Async reset mid-transfer: immediately DP_IDLE, all outputs at reset values; the pending transfer is dropped.
// STRUCTURE
//  - Shared package ahb_pkg: HTRANS/HSIZE/HRESP encodings and DP_* state encodings (also used by the DMA master/bench).
//  - One sub-module ahb_be_gen: combinational (addr[1:0], size) -> {be[3:0], illegal}.
//  - Everything else is flat: FSM, wait counter, address/control registers.
// TESTING
//  1. Reset mid-read (asserted in DP_RD_REQ) -> same cycle CE=0, HREADYOUT=1, HRESP=00, HRDATA=0.
//  2. Word write 0xDEADBEEF @0x10, then word read @0x10, WAIT_STATES=0 -> write BE=1111 ADDR=4 with 0 waits;
//     read returns 0xDEADBEEF after 1 wait.
//  3. Byte write 0xAA @0x21 -> BE=0010, ADDR=8; halfword write @0x22 -> BE=1100; then word read @0x20 shows both merged.
//  4. INCR4 burst of 4 words @0x40 (NONSEQ + 3 SEQ) -> 4 consecutive WR cycles, HREADYOUT stays 1, ADDR 16..19.
//  5. Word read @0x02 -> ERR1 then ERR2 (HRESP=01, HREADYOUT 0 then 1), CE never asserted; next legal read OKAY.
//  6. WAIT_STATES=2, word read @0x0 -> HREADYOUT low for 3 cycles, high on the 4th with data; I_HREADY=0 blocks accept.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM slave's data-phase state type.
// Also imported by the DMA master and benches that talk to the slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        DP_IDLE   = 3'd0,
        DP_WAIT   = 3'd1,
        DP_RD_REQ = 3'd2,
        DP_RD_RSP = 3'd3,
        DP_WR     = 3'd4,
        DP_ERR1   = 3'd5,
        DP_ERR2   = 3'd6
    } dp_state_t;

endpackage

// File: rtl/ahb_be_gen.sv
// Little-endian byte-lane decode for an AHB transfer, plus alignment/size legality.
module ahb_be_gen
    import ahb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] be,
    output logic       illegal
);

    always_comb begin
        be      = '0;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                be      = '1;
                illegal = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a single-port SRAM with one-cycle read latency.
// Address phase is captured on accept; all SRAM traffic happens in the data phase.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET_N,
    input  logic              I_HSEL,
    input  logic [31:0]       I_HADDR,
    input  logic [1:0]        I_HTRANS,
    input  logic              I_HWRITE,
    input  logic [2:0]        I_HSIZE,
    input  logic [2:0]        I_HBURST,
    input  logic [31:0]       I_HWDATA,
    input  logic              I_HREADY,
    output logic              O_HREADYOUT,
    output logic [1:0]        O_HRESP,
    output logic [31:0]       O_HRDATA,
    output logic              O_MEM_CE,
    output logic              O_MEM_WE,
    output logic [ADDR_W-1:0] O_MEM_ADDR,
    output logic [3:0]        O_MEM_BE,
    output logic [31:0]       O_MEM_WDATA,
    input  logic [31:0]       I_MEM_RDATA
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dp_state_t         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;

    logic       accept;
    logic [3:0] gen_be;
    logic       gen_illegal;

    // Burst type and upper address bits carry no information for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{I_HBURST, I_HADDR[31:ADDR_W+2], I_HTRANS[0]};

    ahb_be_gen u_be_gen (
        .addr_lo (I_HADDR[1:0]),
        .size    (I_HSIZE),
        .be      (gen_be),
        .illegal (gen_illegal)
    );

    assign accept = I_HSEL & I_HREADY & I_HTRANS[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        be_d    = be_q;
        case (state_q)
            DP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = write_q ? DP_WR : DP_RD_REQ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DP_RD_REQ: state_d = DP_RD_RSP;
            DP_ERR1:   state_d = DP_ERR2;
            default: begin
                // Ready states double as the next address phase, giving back-to-back pipelining.
                if (accept) begin
                    addr_d  = I_HADDR[ADDR_W+1:2];
                    write_d = I_HWRITE;
                    be_d    = gen_be;
                    if (gen_illegal) begin
                        state_d = DP_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_d = DP_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = I_HWRITE ? DP_WR : DP_RD_REQ;
                    end
                end else begin
                    state_d = DP_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_q <= DP_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        O_HREADYOUT = 1'b1;
        O_HRESP     = HRESP_OKAY;
        O_HRDATA    = '0;
        O_MEM_CE    = 1'b0;
        O_MEM_WE    = 1'b0;
        O_MEM_BE    = '0;
        case (state_q)
            DP_WAIT: O_HREADYOUT = 1'b0;
            DP_RD_REQ: begin
                O_HREADYOUT = 1'b0;
                O_MEM_CE    = 1'b1;
            end
            DP_RD_RSP: O_HRDATA = I_MEM_RDATA;
            DP_WR: begin
                O_MEM_CE = 1'b1;
                O_MEM_WE = 1'b1;
                O_MEM_BE = be_q;
            end
            DP_ERR1: begin
                O_HREADYOUT = 1'b0;
                O_HRESP     = HRESP_ERROR;
            end
            DP_ERR2: O_HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    assign O_MEM_ADDR  = addr_q;
    assign O_MEM_WDATA = I_HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed plus randomized bench for ahb_sram_slave: one instance with no wait
// states and one with two, each backed by an SRAM model and a byte-level reference memory.
module tb_ahb_sram_slave;

    localparam int AW = 10;

    logic clk;
    logic rst_n;

    logic          hsel      [2];
    logic [31:0]   haddr     [2];
    logic [1:0]    htrans    [2];
    logic          hwrite    [2];
    logic [2:0]    hsize     [2];
    logic [2:0]    hburst    [2];
    logic [31:0]   hwdata    [2];
    logic          hready    [2];
    logic          force_low [2];
    logic          hreadyout [2];
    logic [1:0]    hresp     [2];
    logic [31:0]   hrdata    [2];
    logic          mem_ce    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [3:0]    mem_be    [2];
    logic [31:0]   mem_wdata [2];
    logic [31:0]   mem_rdata [2];

    logic [31:0] sram    [2][1024] = '{default: '0};
    logic [31:0] ref_mem [2][1024] = '{default: '0};

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-slave system: global HREADY follows the slave unless a test holds it low.
    assign hready[0] = force_low[0] ? 1'b0 : hreadyout[0];
    assign hready[1] = force_low[1] ? 1'b0 : hreadyout[1];

    ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .I_HCLK(clk), .I_HRESET_N(rst_n), .I_HSEL(hsel[0]), .I_HADDR(haddr[0]),
        .I_HTRANS(htrans[0]), .I_HWRITE(hwrite[0]), .I_HSIZE(hsize[0]), .I_HBURST(hburst[0]),
        .I_HWDATA(hwdata[0]), .I_HREADY(hready[0]), .O_HREADYOUT(hreadyout[0]),
        .O_HRESP(hresp[0]), .O_HRDATA(hrdata[0]), .O_MEM_CE(mem_ce[0]), .O_MEM_WE(mem_we[0]),
        .O_MEM_ADDR(mem_addr[0]), .O_MEM_BE(mem_be[0]), .O_MEM_WDATA(mem_wdata[0]),
        .I_MEM_RDATA(mem_rdata[0])
    );

    ahb_sram_slave #(.ADDR_W(AW), .WAIT_STATES(2)) dut1 (
        .I_HCLK(clk), .I_HRESET_N(rst_n), .I_HSEL(hsel[1]), .I_HADDR(haddr[1]),
        .I_HTRANS(htrans[1]), .I_HWRITE(hwrite[1]), .I_HSIZE(hsize[1]), .I_HBURST(hburst[1]),
        .I_HWDATA(hwdata[1]), .I_HREADY(hready[1]), .O_HREADYOUT(hreadyout[1]),
        .O_HRESP(hresp[1]), .O_HRDATA(hrdata[1]), .O_MEM_CE(mem_ce[1]), .O_MEM_WE(mem_we[1]),
        .O_MEM_ADDR(mem_addr[1]), .O_MEM_BE(mem_be[1]), .O_MEM_WDATA(mem_wdata[1]),
        .I_MEM_RDATA(mem_rdata[1])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ce[d]) begin
                if (mem_we[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[d][b]) sram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
                end else begin
                    mem_rdata[d] <= sram[d][mem_addr[d]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit ref_illegal(input logic [31:0] a, input logic [2:0] s);
        int unsigned n;
        if (s > 3'd2) return 1'b1;
        n = 1 << s;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [2:0] s);
        int unsigned n = 1 << s;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        int unsigned n = 1 << s;
        int unsigned w = (a / 4) % 1024;
        for (int unsigned i = a % 4; i < (a % 4) + n; i++)
            ref_mem[d][w][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic idle_bus(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
        hburst[d] = 3'b000;
    endtask

    // One isolated transfer: address phase, then watch the data phase to completion.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input string tag);
        bit          ill = ref_illegal(a, s);
        int          exp_waits = ill ? 1 : (wr ? ws_of(d) : ws_of(d) + 1);
        logic [1:0]  exp_resp = ill ? 2'b01 : 2'b00;
        int          waits = 0;
        bit          done = 1'b0;
        bit          saw_ce = 1'b0;
        logic [3:0]  be_seen = '0;
        logic [31:0] addr_seen = '0;
        logic [31:0] rd = '0;
        logic [1:0]  resp = '0;
        logic [1:0]  resp_first = '0;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = s; hburst[d] = '0;
        @(posedge clk); #1;
        idle_bus(d);
        hwdata[d] = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) resp_first = hresp[d];
            if (mem_ce[d]) begin
                saw_ce = 1'b1;
                addr_seen = 32'(mem_addr[d]);
                if (mem_we[d]) be_seen = mem_be[d];
            end
            if (hreadyout[d]) begin
                done = 1'b1;
                rd   = hrdata[d];
                resp = hresp[d];
            end else begin
                waits++;
            end
        end
        exp_rd = (!ill && !wr) ? ref_mem[d][(a / 4) % 1024] : 32'h0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_resp_first"}, 32'(resp_first), 32'(exp_resp));
        check({tag, "_resp"}, 32'(resp), 32'(exp_resp));
        check({tag, "_sram_touched"}, 32'(saw_ce), 32'(!ill));
        check({tag, "_rdata"}, rd, exp_rd);
        if (!ill) check({tag, "_mem_addr"}, addr_seen, (a / 4) % 1024);
        if (!ill && wr) begin
            check({tag, "_be"}, 32'(be_seen), 32'(ref_be(a, s)));
            ref_write(d, a, s, wd);
        end
    endtask

    initial begin
        logic [31:0] bdata [4];
        for (int d = 0; d < 2; d++) begin
            idle_bus(d);
            haddr[d] = '0; hsize[d] = '0; hwdata[d] = '0; force_low[d] = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_hreadyout", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("rst%0d_hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("rst%0d_hrdata", d), hrdata[d], 32'd0);
            check($sformatf("rst%0d_ce_we", d), 32'({mem_ce[d], mem_we[d]}), 32'd0);
            check($sformatf("rst%0d_addr_be", d), 32'({mem_addr[d], mem_be[d]}), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted while dut0 is issuing an SRAM read.
        @(posedge clk); #1;
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h10; hwrite[0] = 1'b0; hsize[0] = 3'b010;
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        check("midrd_ce_before", 32'({mem_ce[0], hreadyout[0]}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("midrd_ce", 32'(mem_ce[0]), 32'd0);
        check("midrd_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("midrd_hresp", 32'(hresp[0]), 32'd0);
        check("midrd_hrdata", hrdata[0], 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, "wr_word10");
        xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, "rd_word10");
        check("rd_word10_value", ref_mem[0][4], 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h21, 3'b000, 32'h0000AA00, "wr_byte21");
        xfer(0, 1'b1, 32'h22, 3'b001, 32'h12340000, "wr_half22");
        xfer(0, 1'b0, 32'h20, 3'b010, 32'h0, "rd_merge20");
        check("rd_merge20_value", ref_mem[0][8], 32'h1234AA00);

        // INCR4 write burst, address phases overlapping data phases.
        for (int b = 0; b < 4; b++) bdata[b] = $urandom;
        @(posedge clk); #1;
        for (int b = 0; b < 5; b++) begin
            if (b < 4) begin
                hsel[0] = 1'b1; htrans[0] = (b == 0) ? 2'b10 : 2'b11; haddr[0] = 32'h40 + 32'(4 * b);
                hwrite[0] = 1'b1; hsize[0] = 3'b010; hburst[0] = 3'b011;
            end else begin
                idle_bus(0);
            end
            if (b > 0) begin
                hwdata[0] = bdata[b-1];
                @(negedge clk);
                check($sformatf("burst%0d_hreadyout", b-1), 32'(hreadyout[0]), 32'd1);
                check($sformatf("burst%0d_ce_we", b-1), 32'({mem_ce[0], mem_we[0]}), 32'b11);
                check($sformatf("burst%0d_addr", b-1), 32'(mem_addr[0]), 32'(16 + b - 1));
                check($sformatf("burst%0d_be", b-1), 32'(mem_be[0]), 32'hF);
                ref_write(0, 32'h40 + 32'(4 * (b-1)), 3'b010, bdata[b-1]);
            end
            @(posedge clk); #1;
        end
        for (int b = 0; b < 4; b++)
            xfer(0, 1'b0, 32'h40 + 32'(4 * b), 3'b010, 32'h0, $sformatf("burst_rb%0d", b));

        xfer(0, 1'b0, 32'h02, 3'b010, 32'h0, "rd_misaligned");
        xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, "rd_after_err");

        // BUSY with HSEL must not start a transfer.
        @(posedge clk); #1;
        hsel[0] = 1'b1; htrans[0] = 2'b01; haddr[0] = 32'h08; hwrite[0] = 1'b1; hsize[0] = 3'b010;
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        check("busy_ready_resp", 32'({hreadyout[0], hresp[0]}), 32'b100);
        check("busy_no_ce", 32'(mem_ce[0]), 32'd0);

        xfer(1, 1'b0, 32'h0, 3'b010, 32'h0, "ws2_rd0");
        xfer(1, 1'b1, 32'h30, 3'b010, 32'hCAFEF00D, "ws2_wr30");

        // Global HREADY low: the address phase is presented but must never be taken.
        @(posedge clk); #1;
        force_low[1] = 1'b1;
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'b010;
        hwdata[1] = 32'h0BADBAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hrdylow%0d_idle", c), 32'({hreadyout[1], mem_ce[1]}), 32'b10);
        end
        @(posedge clk); #1;
        idle_bus(1);
        force_low[1] = 1'b0;
        xfer(1, 1'b0, 32'h30, 3'b010, 32'h0, "ws2_rd30_unchanged");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 25; i++) begin
                logic [2:0]  s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                             : 3'($urandom_range(0, 2));
                logic [31:0] a = 32'($urandom_range(0, 127));
                xfer(d, 1'($urandom_range(0, 1)), a, s, $urandom, $sformatf("rnd%0d_%0d", d, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
